// File: rtl/rs_lab_pkg.sv
// Shared definitions for the sequential_logic lab input conditioning blocks:
// per-channel debounce state encoding and the debounce counter width helper.
package rs_lab_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        HIGH   = 2'd2,
        DISARM = 2'd3
    } chan_state_t;

    // Width able to hold 0..cycles; the counter never goes past cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchroniser, debounce FSM and counter.
// Reports the debounced level and a one-cycle request on each accepted press.
module debounce_channel
    import rs_lab_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic lvl,
    output logic press_req
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    chan_state_t      state;
    chan_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt counts consecutive sync2 samples that disagree with the accepted level.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_next = ARMING;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            ARMING: begin
                if (!sync2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_next = DISARM;
                    cnt_next   = CNT_ONE;
                end
            end
            DISARM: begin
                if (sync2) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Request is combinational so the top-level register fires on the accepting edge.
    always_comb begin
        lvl       = (state == HIGH) || (state == DISARM);
        press_req = (state == ARMING) && sync2 && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/rs_input_conditioner.sv
// Conditions raw set/reset push-buttons into single-cycle S/R pulses for the
// clocked RS flip-flop; coincident presses raise Conflict instead of S=R=1.
module rs_input_conditioner
    import rs_lab_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn_S,
    input  logic Btn_R,
    output logic S,
    output logic R,
    output logic Conflict,
    output logic Lvl_S,
    output logic Lvl_R
);

    logic req_s;
    logic req_r;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_s (
        .clk       (Clk),
        .rst       (Rst),
        .btn       (Btn_S),
        .lvl       (Lvl_S),
        .press_req (req_s)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_r (
        .clk       (Clk),
        .rst       (Rst),
        .btn       (Btn_R),
        .lvl       (Lvl_R),
        .press_req (req_r)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            S        <= 1'b0;
            R        <= 1'b0;
            Conflict <= 1'b0;
        end else begin
            S        <= req_s & ~req_r;
            R        <= req_r & ~req_s;
            Conflict <= req_s & req_r;
        end
    end

endmodule

// File: tb/tb_rs_input_conditioner.sv
// Bench for rs_input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios
// followed by random bouncy stimulus, all checked against a run-length model.
module tb_rs_input_conditioner;

    localparam int D = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic Btn_S = 1'b0;
    logic Btn_R = 1'b0;
    logic S, R, Conflict, Lvl_S, Lvl_R;

    rs_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Btn_S    (Btn_S),
        .Btn_R    (Btn_R),
        .S        (S),
        .R        (R),
        .Conflict (Conflict),
        .Lvl_S    (Lvl_S),
        .Lvl_R    (Lvl_R)
    );

    always #5 Clk = ~Clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: two-sample delay, then the level flips after D consecutive disagreeing samples.
    logic m_p1[2] = '{1'b0, 1'b0};
    logic m_p2[2] = '{1'b0, 1'b0};
    logic m_lvl[2] = '{1'b0, 1'b0};
    int   m_run[2] = '{0, 0};
    logic exp_s = 1'b0, exp_r = 1'b0, exp_c = 1'b0;

    int unsigned seen_s = 0, seen_r = 0, seen_c = 0;
    int unsigned lvl_s_drop = 0;
    int hold_s = 0, hold_r = 0;
    logic vs = 1'b0, vr = 1'b0;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic bs, input logic br);
        logic req[2];
        logic btn[2];
        btn[0] = bs;
        btn[1] = br;
        for (int c = 0; c < 2; c++) begin
            req[c] = 1'b0;
            if (rst_v) begin
                m_p1[c]  = 1'b0;
                m_p2[c]  = 1'b0;
                m_lvl[c] = 1'b0;
                m_run[c] = 0;
            end else begin
                if (m_p2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c] = ~m_lvl[c];
                        m_run[c] = 0;
                        req[c]   = m_lvl[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_p2[c] = m_p1[c];
                m_p1[c] = btn[c];
            end
        end
        exp_s = req[0] & ~req[1];
        exp_r = req[1] & ~req[0];
        exp_c = req[0] & req[1];
    endtask

    task automatic step(input logic rst_v, input logic bs, input logic br);
        @(negedge Clk);
        Rst   = rst_v;
        Btn_S = bs;
        Btn_R = br;
        @(posedge Clk);
        model_edge(rst_v, bs, br);
        #1;
        check("S", S, exp_s);
        check("R", R, exp_r);
        check("Conflict", Conflict, exp_c);
        check("Lvl_S", Lvl_S, m_lvl[0]);
        check("Lvl_R", Lvl_R, m_lvl[1]);
        check("S_and_R", S & R, 1'b0);
        seen_s += S;
        seen_r += R;
        seen_c += Conflict;
        if (!Lvl_S) lvl_s_drop++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset with both buttons held, then release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check("rst_S", S, 1'b0);
            check("rst_Lvl_S", Lvl_S, 1'b0);
        end
        seen_s = 0; seen_r = 0; seen_c = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 5) check("s1_conflict_before", Conflict, 1'b0);
            if (i == 6) check("s1_conflict_edge6", Conflict, 1'b1);
        end
        check("s1_conflict_once", seen_c == 1, 1'b1);
        check("s1_no_sr", (seen_s + seen_r) == 0, 1'b1);
        idle(8);

        // 2: clean set press held for 20 cycles
        seen_s = 0; seen_r = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 5) check("s2_S_edge5", S, 1'b0);
            if (i == 6) begin
                check("s2_S_edge6", S, 1'b1);
                check("s2_Lvl_S_edge6", Lvl_S, 1'b1);
            end
            if (i == 7) check("s2_S_edge7", S, 1'b0);
        end
        check("s2_one_pulse", seen_s == 1, 1'b1);
        check("s2_no_R", seen_r == 0, 1'b1);
        idle(8);

        // 3: bouncing reset button
        seen_r = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, (i >= 5) ? 1'b1 : logic'(i % 2));
            if (i == 9) check("s3_R_edge9", R, 1'b0);
            if (i == 10) check("s3_R_edge10", R, 1'b1);
        end
        check("s3_one_pulse", seen_r == 1, 1'b1);
        idle(8);

        // 4: release glitch after accepted set press
        seen_s = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        lvl_s_drop = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        check("s4_lvl_held", lvl_s_drop == 0, 1'b1);
        check("s4_one_pulse", seen_s == 1, 1'b1);
        idle(8);

        // 5: simultaneous press, then reset-only press while set is held
        seen_s = 0; seen_r = 0; seen_c = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 6) check("s5_conflict_edge6", Conflict, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        check("s5_Lvl_R_released", Lvl_R, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 6) check("s5_R_edge6", R, 1'b1);
        end
        check("s5_no_S", seen_s == 0, 1'b1);
        check("s5_counts", (seen_r == 1) && (seen_c == 1), 1'b1);
        idle(8);

        // 6: reset mid-arm with the set button held throughout
        seen_s = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 2) check("s6_S_orig_time", S, 1'b0);
            if (i == 6) check("s6_S_after_reset", S, 1'b1);
        end
        check("s6_one_pulse", seen_s == 1, 1'b1);
        idle(8);

        // Random bouncy buttons with occasional reset
        for (int i = 0; i < 3000; i++) begin
            if (hold_s == 0) begin
                vs = logic'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 9);
            end
            if (hold_r == 0) begin
                vr = logic'($urandom_range(0, 1));
                hold_r = $urandom_range(1, 9);
            end
            hold_s--;
            hold_r--;
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, vs, vr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
